// File: rtl/systolic_input_skewer.sv
// Feeds a captured ROWS x COLS operand matrix into the array edge as a diagonal
// wavefront: lane r runs r beats behind lane 0, and downstream can stall it.
module systolic_input_skewer #(
    parameter int WORD_SIZE = 16,
    parameter int ROWS      = 4,
    parameter int COLS      = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [ROWS*COLS*WORD_SIZE-1:0] in_matrix,
    input  logic                           advance,
    output logic                           in_ready,
    output logic [ROWS*WORD_SIZE-1:0]      lane_bus,
    output logic [ROWS-1:0]                lane_valid,
    output logic                           busy,
    output logic                           done
);

    localparam int BEATS = ROWS + COLS - 1;
    localparam int CW    = $clog2(ROWS + COLS);
    localparam logic [CW-1:0] END_T = CW'(BEATS);

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DONE
    } state_t;

    state_t                         state, state_nxt;
    logic [CW-1:0]                  t, t_nxt;
    logic [ROWS*COLS*WORD_SIZE-1:0] snap;
    logic                           load;
    logic [ROWS*WORD_SIZE-1:0]      lane_bus_nxt;
    logic [ROWS-1:0]                lane_valid_nxt;
    logic [ROWS*COLS*WORD_SIZE-1:0] src;
    logic [CW-1:0]                  beat_t;
    logic [ROWS*WORD_SIZE-1:0]      beat_bus;
    logic [ROWS-1:0]                beat_valid;

    // Beat 0 goes out on the accepting edge, before the snapshot register has loaded,
    // so in IDLE the beat is built straight from in_matrix.
    always_comb begin
        int idx;
        src        = (state == IDLE) ? in_matrix : snap;
        beat_t     = (state == IDLE) ? '0 : t;
        beat_bus   = '0;
        beat_valid = '0;
        idx        = 0;
        for (int r = 0; r < ROWS; r++) begin
            idx = int'(beat_t) - r;
            if (idx >= 0 && idx < COLS) begin
                beat_bus[r*WORD_SIZE +: WORD_SIZE] = src[(r*COLS+idx)*WORD_SIZE +: WORD_SIZE];
                beat_valid[r] = 1'b1;
            end
        end
    end

    // t counts beats already on the bus; the advance that consumes the last beat ends FEED.
    always_comb begin
        state_nxt      = state;
        t_nxt          = t;
        load           = 1'b0;
        lane_bus_nxt   = lane_bus;
        lane_valid_nxt = lane_valid;
        case (state)
            IDLE: begin
                if (start) begin
                    load           = 1'b1;
                    state_nxt      = FEED;
                    t_nxt          = '0;
                    lane_bus_nxt   = '0;
                    lane_valid_nxt = '0;
                    if (advance) begin
                        lane_bus_nxt   = beat_bus;
                        lane_valid_nxt = beat_valid;
                        t_nxt          = CW'(1);
                    end
                end
            end
            FEED: begin
                if (advance) begin
                    if (t == END_T) begin
                        state_nxt      = DONE;
                        lane_bus_nxt   = '0;
                        lane_valid_nxt = '0;
                    end else begin
                        lane_bus_nxt   = beat_bus;
                        lane_valid_nxt = beat_valid;
                        t_nxt          = t + 1'b1;
                    end
                end
            end
            DONE: begin
                state_nxt      = IDLE;
                t_nxt          = '0;
                lane_bus_nxt   = '0;
                lane_valid_nxt = '0;
            end
            default: begin
                state_nxt      = IDLE;
                t_nxt          = '0;
                lane_bus_nxt   = '0;
                lane_valid_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            t          <= '0;
            snap       <= '0;
            lane_bus   <= '0;
            lane_valid <= '0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            t          <= t_nxt;
            lane_bus   <= lane_bus_nxt;
            lane_valid <= lane_valid_nxt;
            in_ready   <= (state_nxt == IDLE);
            busy       <= (state_nxt == FEED);
            done       <= (state_nxt == DONE);
            if (load) begin
                snap <= in_matrix;
            end
        end
    end

endmodule

// File: tb/tb_systolic_input_skewer.sv
// Bench for systolic_input_skewer: directed wavefront scenarios with literal pins,
// then random start/advance/matrix traffic against a beat-count reference model.
module tb_systolic_input_skewer;

    localparam int W     = 16;
    localparam int R     = 4;
    localparam int C     = 4;
    localparam int BEATS = R + C - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               advance;
    logic [R*C*W-1:0]   in_matrix;
    logic               in_ready;
    logic [R*W-1:0]     lane_bus;
    logic [R-1:0]       lane_valid;
    logic               busy;
    logic               done;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    systolic_input_skewer #(.WORD_SIZE(W), .ROWS(R), .COLS(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_matrix (in_matrix),
        .advance   (advance),
        .in_ready  (in_ready),
        .lane_bus  (lane_bus),
        .lane_valid(lane_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] elem(input logic [R*C*W-1:0] m, input int r, input int c);
        return m[(r*C+c)*W +: W];
    endfunction

    function automatic logic [R*C*W-1:0] pattern(input int base);
        logic [R*C*W-1:0] m;
        m = '0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                m[(r*C+c)*W +: W] = W'(base + 16*r + c + 1);
        return m;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic a);
        start   = s;
        advance = a;
        @(negedge clk);
    endtask

    // Reference: mode 0 idle / 1 streaming / 2 done; m_cnt = beats shown so far.
    int               m_mode;
    int               m_cnt;
    logic [R*C*W-1:0] m_snap;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode <= 0;
            m_cnt  <= 0;
            m_snap <= '0;
        end else begin
            case (m_mode)
                0: if (start) begin
                    m_mode <= 1;
                    m_cnt  <= advance ? 1 : 0;
                    m_snap <= in_matrix;
                end
                1: if (advance) begin
                    if (m_cnt == BEATS) m_mode <= 2;
                    else                m_cnt  <= m_cnt + 1;
                end
                default: begin
                    m_mode <= 0;
                    m_cnt  <= 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        logic [R*W-1:0] eb;
        logic [R-1:0]   ev;
        int             b;
        if (chk_on) begin
            eb = '0;
            ev = '0;
            b  = m_cnt - 1;
            if (m_mode == 1 && m_cnt >= 1) begin
                for (int r = 0; r < R; r++) begin
                    if (b - r >= 0 && b - r < C) begin
                        eb[r*W +: W] = elem(m_snap, r, b - r);
                        ev[r]        = 1'b1;
                    end
                end
            end
            checkOutput("lane_bus",   64'(lane_bus),   64'(eb));
            checkOutput("lane_valid", 64'(lane_valid), 64'(ev));
            checkOutput("in_ready",   64'(in_ready),   64'(m_mode == 0));
            checkOutput("busy",       64'(busy),       64'(m_mode == 1));
            checkOutput("done",       64'(done),       64'(m_mode == 2));
        end
    end

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        advance   = 1'b0;
        in_matrix = '0;
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        checkOutput("rst_in_ready", 64'(in_ready),   64'd1);
        checkOutput("rst_lane_bus", 64'(lane_bus),   64'd0);
        checkOutput("rst_valid",    64'(lane_valid), 64'd0);
        checkOutput("rst_busy",     64'(busy),       64'd0);
        checkOutput("rst_done",     64'(done),       64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Basic stream, with a second start and a matrix change while busy
        in_matrix = pattern(0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("basic_t0_bus",   64'(lane_bus),   64'h0000_0000_0000_0001);
        checkOutput("basic_t0_valid", 64'(lane_valid), 64'b0001);
        applyStimulus(1'b0, 1'b1);
        checkOutput("basic_t1_bus",   64'(lane_bus),   64'h0000_0000_0011_0002);
        checkOutput("basic_t1_valid", 64'(lane_valid), 64'b0011);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("basic_t3_bus",   64'(lane_bus),   64'h0031_0022_0013_0004);
        checkOutput("basic_t3_valid", 64'(lane_valid), 64'b1111);
        in_matrix = pattern(1000);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("basic_t6_bus",   64'(lane_bus),   64'h0034_0000_0000_0000);
        checkOutput("basic_t6_valid", 64'(lane_valid), 64'b1000);
        applyStimulus(1'b0, 1'b1);
        checkOutput("basic_done",     64'(done),       64'd1);
        checkOutput("basic_done_vld", 64'(lane_valid), 64'd0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("basic_ready",    64'(in_ready),   64'd1);

        // Back-to-back stream from the first idle cycle
        in_matrix = pattern(200);
        applyStimulus(1'b1, 1'b1);
        checkOutput("b2b_t0_bus", 64'(lane_bus), 64'h0000_0000_0000_00C9);
        repeat (8) applyStimulus(1'b0, 1'b1);

        // Stall three cycles at t=2, matrix forced to all ones meanwhile
        in_matrix = pattern(0);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("stall_t2_bus",   64'(lane_bus),   64'h0000_0021_0012_0003);
        checkOutput("stall_t2_valid", 64'(lane_valid), 64'b0111);
        in_matrix = '1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput("stall_hold_bus",   64'(lane_bus),   64'h0000_0021_0012_0003);
            checkOutput("stall_hold_valid", 64'(lane_valid), 64'b0111);
        end
        repeat (4) applyStimulus(1'b0, 1'b1);
        checkOutput("stall_t6_bus", 64'(lane_bus), 64'h0034_0000_0000_0000);
        applyStimulus(1'b0, 1'b1);
        checkOutput("stall_done", 64'(done), 64'd1);
        applyStimulus(1'b0, 1'b0);

        // Asynchronous reset in the middle of a stream
        in_matrix = pattern(0);
        applyStimulus(1'b1, 1'b1);
        repeat (4) applyStimulus(1'b0, 1'b1);
        #2 rst = 1'b0;
        #1;
        checkOutput("abort_bus",   64'(lane_bus),   64'd0);
        checkOutput("abort_valid", 64'(lane_valid), 64'd0);
        checkOutput("abort_ready", 64'(in_ready),   64'd1);
        checkOutput("abort_busy",  64'(busy),       64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b1);
        checkOutput("abort_no_done", 64'(done), 64'd0);
        in_matrix = pattern(500);
        applyStimulus(1'b1, 1'b1);
        checkOutput("fresh_t0_bus", 64'(lane_bus), 64'h0000_0000_0000_01F5);
        repeat (8) applyStimulus(1'b0, 1'b1);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            for (int e = 0; e < R*C; e++)
                in_matrix[e*W +: W] = W'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
        end
        repeat (12) applyStimulus(1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
